hazard_ctrl: RTL and testbench

- Pipeline scheduler for the execute stage.
- Selects the operand forwarding source (forward_sig1/2) and detects load-use hazards.
- Sequences multi-cycle execute ops, such as an iterative divider, by stalling the front end until done.
- Issues flushes on a taken branch. Sits beside the D/E/M/W pipeline registers and drives their stall/flush inputs.

---
 rtl/hazard_ctrl_pkg.sv | 26 ++
 rtl/hazard_ctrl_fwd_sel.sv | 26 ++
 rtl/hazard_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the execute-stage hazard controller: forwarding selects,
// load-type marker, boolean helpers and the multi-cycle sequencer states.
package hazard_ctrl_pkg;

    localparam logic [1:0] NORMAL    = 2'b00;
    localparam logic [1:0] WRITEMEM  = 2'b01;
    localparam logic [1:0] WRITEBACK = 2'b10;

    localparam logic [2:0] NOTLOAD = 3'b000;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MC_BUSY = 1'b1
    } mc_state_e;

    // A later stage supplies rs only if it really writes a non-x0 register equal to rs.
    function automatic logic reg_hit(input logic       we,
                                     input logic [4:0] dst,
                                     input logic [4:0] src);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Combinational forwarding select for one execute-stage operand; memory stage
// wins over writeback, x0 is never forwarded, NORMAL while i_en is low.
module hazard_ctrl_fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic       i_en,
    input  logic [4:0] i_rs_addr,
    input  logic       i_write_regM,
    input  logic [4:0] i_dstreg_addrM,
    input  logic       i_write_regW,
    input  logic [4:0] i_dstreg_addrW,
    output logic [1:0] o_sel
);

    always_comb begin
        o_sel = NORMAL;
        if (i_en) begin
            if (reg_hit(i_write_regM, i_dstreg_addrM, i_rs_addr)) begin
                o_sel = WRITEMEM;
            end else if (reg_hit(i_write_regW, i_dstreg_addrW, i_rs_addr)) begin
                o_sel = WRITEBACK;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Execute-stage hazard controller: forwarding selects, load-use stall, multi-cycle
// op sequencing with watchdog, and branch flush. HAZARD_PERF_EN adds perf counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MC_MAX_CYCLES = 64,
    parameter int CNT_W         = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] i_rs1_addrD,
    input  logic [4:0] i_rs2_addrD,
    input  logic       i_uses_rs1D,
    input  logic       i_uses_rs2D,
    input  logic [4:0] i_rs1_addrE,
    input  logic [4:0] i_rs2_addrE,
    input  logic       i_write_regE,
    input  logic [4:0] i_dstreg_addrE,
    input  logic [2:0] i_info_loadE,
    input  logic       i_write_regM,
    input  logic [4:0] i_dstreg_addrM,
    input  logic       i_write_regW,
    input  logic [4:0] i_dstreg_addrW,
    input  logic       i_branch_signal,
    input  logic       i_mc_start,
    input  logic       i_mc_done,
    output logic [1:0] o_forward_sig1,
    output logic [1:0] o_forward_sig2,
    output logic       o_stallF,
    output logic       o_stallD,
    output logic       o_stallE,
    output logic       o_flushD,
    output logic       o_flushE,
    output logic       o_mc_abort,
    output logic       o_mc_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] o_perf_ldstall,
    output logic [CNT_W-1:0] o_perf_mcstall,
    output logic [CNT_W-1:0] o_perf_flush
`endif
);

    localparam int MC_CNT_W = (MC_MAX_CYCLES > 2) ? $clog2(MC_MAX_CYCLES) : 1;
    localparam logic [MC_CNT_W-1:0] MC_LAST = MC_CNT_W'(MC_MAX_CYCLES - 1);

    mc_state_e           r_state;
    mc_state_e           w_state_next;
    logic [MC_CNT_W-1:0] r_cnt;
    logic [MC_CNT_W-1:0] w_cnt_next;
    logic                r_mc_timeout;
    logic                w_timeout_set;

    logic [4:0] w_rs_addrE [2];
    logic [1:0] w_fwd_sel  [2];
    logic       w_lu_src1;
    logic       w_lu_src2;
    logic       w_load_use;

    assign w_rs_addrE[0] = i_rs1_addrE;
    assign w_rs_addrE[1] = i_rs2_addrE;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            hazard_ctrl_fwd_sel u_fwd_sel (
                .i_en           (rst_n),
                .i_rs_addr      (w_rs_addrE[gi]),
                .i_write_regM   (i_write_regM),
                .i_dstreg_addrM (i_dstreg_addrM),
                .i_write_regW   (i_write_regW),
                .i_dstreg_addrW (i_dstreg_addrW),
                .o_sel          (w_fwd_sel[gi])
            );
        end
    endgenerate

    assign o_forward_sig1 = w_fwd_sel[0];
    assign o_forward_sig2 = w_fwd_sel[1];

    // Load data only exists after M, so a dependent decode op must wait one slot.
    assign w_lu_src1  = i_uses_rs1D && (i_rs1_addrD == i_dstreg_addrE);
    assign w_lu_src2  = i_uses_rs2D && (i_rs2_addrD == i_dstreg_addrE);
    assign w_load_use = (i_info_loadE != NOTLOAD) && i_write_regE &&
                        (i_dstreg_addrE != 5'd0) && (w_lu_src1 || w_lu_src2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_mc_timeout <= FALSE;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_timeout_set) begin
                r_mc_timeout <= TRUE;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_timeout_set = FALSE;
        o_stallF      = FALSE;
        o_stallD      = FALSE;
        o_stallE      = FALSE;
        o_flushD      = FALSE;
        o_flushE      = FALSE;
        o_mc_abort    = FALSE;

        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                if (i_mc_start && !i_branch_signal) begin
                    w_state_next = ST_MC_BUSY;
                end
                if (w_load_use && !i_branch_signal) begin
                    o_stallF = TRUE;
                    o_stallD = TRUE;
                    o_flushE = TRUE;
                end
            end
            ST_MC_BUSY: begin
                if (i_branch_signal || i_mc_done) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    o_stallF = TRUE;
                    o_stallD = TRUE;
                    o_stallE = TRUE;
                    if (r_cnt == MC_LAST) begin
                        w_state_next  = ST_IDLE;
                        w_cnt_next    = '0;
                        w_timeout_set = TRUE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase

        if (i_branch_signal) begin
            o_flushD   = TRUE;
            o_flushE   = TRUE;
            o_mc_abort = (r_state == ST_MC_BUSY) || i_mc_start;
        end

        // Outputs must read idle while reset is held, independent of the clock.
        if (!rst_n) begin
            o_stallF   = FALSE;
            o_stallD   = FALSE;
            o_stallE   = FALSE;
            o_flushD   = FALSE;
            o_flushE   = FALSE;
            o_mc_abort = FALSE;
        end
    end

    assign o_mc_timeout = r_mc_timeout;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_perf_ldstall;
    logic [CNT_W-1:0] r_perf_mcstall;
    logic [CNT_W-1:0] r_perf_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_ldstall <= '0;
            r_perf_mcstall <= '0;
            r_perf_flush   <= '0;
        end else begin
            if ((r_state == ST_IDLE) && o_stallD && (r_perf_ldstall != '1)) begin
                r_perf_ldstall <= r_perf_ldstall + 1'b1;
            end
            if ((r_state == ST_MC_BUSY) && (r_perf_mcstall != '1)) begin
                r_perf_mcstall <= r_perf_mcstall + 1'b1;
            end
            if (i_branch_signal && (r_perf_flush != '1)) begin
                r_perf_flush <= r_perf_flush + 1'b1;
            end
        end
    end

    assign o_perf_ldstall = r_perf_ldstall;
    assign o_perf_mcstall = r_perf_mcstall;
    assign o_perf_flush   = r_perf_flush;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two instances (watchdog 64 and 8) driven
// by shared directed and random stimulus, compared against a cycle-level model.
module tb_hazard_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [4:0] rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE;
    logic       uses_rs1D, uses_rs2D;
    logic       write_regE, write_regM, write_regW;
    logic [4:0] dstreg_addrE, dstreg_addrM, dstreg_addrW;
    logic [2:0] info_loadE;
    logic       branch_signal, mc_start, mc_done;

    logic [1:0] f1_a, f2_a, f1_b, f2_b;
    logic       sf_a, sd_a, se_a, fd_a, fe_a, ab_a, to_a;
    logic       sf_b, sd_b, se_b, fd_b, fe_b, ab_b, to_b;
    logic [10:0] got_a, got_b;

    assign got_a = {f1_a, f2_a, sf_a, sd_a, se_a, fd_a, fe_a, ab_a, to_a};
    assign got_b = {f1_b, f2_b, sf_b, sd_b, se_b, fd_b, fe_b, ab_b, to_b};

`ifdef HAZARD_PERF_EN
    logic [31:0] pld_a, pmc_a, pfl_a, pld_b, pmc_b, pfl_b;
`endif

    hazard_ctrl #(.MC_MAX_CYCLES(64)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_rs1_addrD(rs1_addrD), .i_rs2_addrD(rs2_addrD),
        .i_uses_rs1D(uses_rs1D), .i_uses_rs2D(uses_rs2D),
        .i_rs1_addrE(rs1_addrE), .i_rs2_addrE(rs2_addrE),
        .i_write_regE(write_regE), .i_dstreg_addrE(dstreg_addrE), .i_info_loadE(info_loadE),
        .i_write_regM(write_regM), .i_dstreg_addrM(dstreg_addrM),
        .i_write_regW(write_regW), .i_dstreg_addrW(dstreg_addrW),
        .i_branch_signal(branch_signal), .i_mc_start(mc_start), .i_mc_done(mc_done),
        .o_forward_sig1(f1_a), .o_forward_sig2(f2_a),
        .o_stallF(sf_a), .o_stallD(sd_a), .o_stallE(se_a),
        .o_flushD(fd_a), .o_flushE(fe_a), .o_mc_abort(ab_a), .o_mc_timeout(to_a)
`ifdef HAZARD_PERF_EN
        , .o_perf_ldstall(pld_a), .o_perf_mcstall(pmc_a), .o_perf_flush(pfl_a)
`endif
    );

    hazard_ctrl #(.MC_MAX_CYCLES(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .i_rs1_addrD(rs1_addrD), .i_rs2_addrD(rs2_addrD),
        .i_uses_rs1D(uses_rs1D), .i_uses_rs2D(uses_rs2D),
        .i_rs1_addrE(rs1_addrE), .i_rs2_addrE(rs2_addrE),
        .i_write_regE(write_regE), .i_dstreg_addrE(dstreg_addrE), .i_info_loadE(info_loadE),
        .i_write_regM(write_regM), .i_dstreg_addrM(dstreg_addrM),
        .i_write_regW(write_regW), .i_dstreg_addrW(dstreg_addrW),
        .i_branch_signal(branch_signal), .i_mc_start(mc_start), .i_mc_done(mc_done),
        .o_forward_sig1(f1_b), .o_forward_sig2(f2_b),
        .o_stallF(sf_b), .o_stallD(sd_b), .o_stallE(se_b),
        .o_flushD(fd_b), .o_flushE(fe_b), .o_mc_abort(ab_b), .o_mc_timeout(to_b)
`ifdef HAZARD_PERF_EN
        , .o_perf_ldstall(pld_b), .o_perf_mcstall(pmc_b), .o_perf_flush(pfl_b)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    // Reference model: per instance, busy flag, completed busy cycles, sticky timeout.
    int mmax   [2] = '{64, 8};
    bit m_busy [2];
    int m_cyc  [2];
    bit m_to   [2];
    int p_ld   [2];
    int p_mc   [2];
    int p_fl   [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (write_regM && dstreg_addrM != 0 && dstreg_addrM == rs) return 2'b01;
        if (write_regW && dstreg_addrW != 0 && dstreg_addrW == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit ref_lu();
        return (info_loadE != 3'b000) && write_regE && (dstreg_addrE != 0) &&
               ((uses_rs1D && rs1_addrD == dstreg_addrE) ||
                (uses_rs2D && rs2_addrD == dstreg_addrE));
    endfunction

    function automatic logic [10:0] ref_out(input int k);
        bit mc_hold, front, fe, ab;
        if (!rst_n) return 11'b0;
        mc_hold = m_busy[k] && !mc_done && !branch_signal;
        front   = mc_hold || (!m_busy[k] && ref_lu() && !branch_signal);
        fe      = branch_signal || (!m_busy[k] && ref_lu());
        ab      = branch_signal && (m_busy[k] || mc_start);
        return {ref_fwd(rs1_addrE), ref_fwd(rs2_addrE), front, front, mc_hold,
                branch_signal, fe, ab, m_to[k]};
    endfunction

    task automatic model_clock();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_busy[k] = 0; m_cyc[k] = 0; m_to[k] = 0;
                p_ld[k] = 0; p_mc[k] = 0; p_fl[k] = 0;
            end else begin
                if (!m_busy[k] && ref_lu() && !branch_signal) p_ld[k]++;
                if (m_busy[k]) p_mc[k]++;
                if (branch_signal) p_fl[k]++;
                if (m_busy[k]) begin
                    if (branch_signal || mc_done) begin
                        m_busy[k] = 0;
                    end else begin
                        m_cyc[k]++;
                        if (m_cyc[k] == mmax[k]) begin
                            m_busy[k] = 0;
                            m_to[k]   = 1;
                        end
                    end
                end else if (mc_start && !branch_signal) begin
                    m_busy[k] = 1;
                    m_cyc[k]  = 0;
                end
            end
        end
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic advance(input string tag);
        check({tag, "_a"}, 32'(got_a), 32'(ref_out(0)));
        check({tag, "_b"}, 32'(got_b), 32'(ref_out(1)));
        $display("[TB] cycle %0d %s dut=%03h dut8=%03h", cycle, tag, got_a, got_b);
        model_clock();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic clear_inputs();
        rs1_addrD = 0; rs2_addrD = 0; uses_rs1D = 0; uses_rs2D = 0;
        rs1_addrE = 0; rs2_addrE = 0;
        write_regE = 0; dstreg_addrE = 0; info_loadE = 3'b000;
        write_regM = 0; dstreg_addrM = 0; write_regW = 0; dstreg_addrW = 0;
        branch_signal = 0; mc_start = 0; mc_done = 0;
    endtask

    initial begin
        clear_inputs();
        #1 rst_n = 1'b0;
        @(posedge clk); #1;

        // Reset: busy-looking inputs still give idle outputs.
        write_regM = 1; dstreg_addrM = 5; rs1_addrE = 5; branch_signal = 1;
        settle();
        check("rst_fwd1", 32'(f1_a), 32'd0);
        check("rst_flushD", 32'(fd_a), 32'd0);
        advance("reset");
        clear_inputs();
        rst_n = 1'b1;
        settle(); advance("idle");

        // Forwarding priority and x0.
        write_regM = 1; dstreg_addrM = 5; write_regW = 1; dstreg_addrW = 5; rs1_addrE = 5;
        settle(); check("fwd_mem", 32'(f1_a), 32'd1); advance("fwd_mem");
        write_regM = 0;
        settle(); check("fwd_wb", 32'(f1_a), 32'd2); advance("fwd_wb");
        rs1_addrE = 0; dstreg_addrM = 0; dstreg_addrW = 0;
        settle(); check("fwd_x0", 32'(f1_a), 32'd0); advance("fwd_x0");
        clear_inputs();

        // Load-use on x7, then the load moves to M and W.
        info_loadE = 3'b010; write_regE = 1; dstreg_addrE = 7; uses_rs2D = 1; rs2_addrD = 7;
        settle(); check("lu_stallD", 32'(sd_a), 32'd1); check("lu_flushE", 32'(fe_a), 32'd1);
        advance("lu_hit");
        info_loadE = 0; write_regE = 0; dstreg_addrE = 0; write_regM = 1; dstreg_addrM = 7;
        settle(); check("lu_once", 32'(sd_a), 32'd0); advance("lu_bubble");
        write_regM = 0; dstreg_addrM = 0; write_regW = 1; dstreg_addrW = 7;
        rs2_addrE = 7; uses_rs2D = 0; rs2_addrD = 0;
        settle(); check("lu_fwd_wb", 32'(f2_a), 32'd2); advance("lu_consume");
        clear_inputs();
        info_loadE = 3'b010; write_regE = 1; dstreg_addrE = 7; uses_rs2D = 0; rs2_addrD = 7;
        settle(); check("lu_unused", 32'(sd_a), 32'd0); advance("lu_unused");
        uses_rs2D = 1; dstreg_addrE = 0; rs2_addrD = 0;
        settle(); check("lu_x0", 32'(sd_a), 32'd0); advance("lu_x0");
        clear_inputs();

        // Ten-cycle multi-cycle op; the 8-cycle watchdog instance times out.
        mc_start = 1; settle(); advance("mc_start");
        mc_start = 0;
        for (int i = 0; i < 10; i++) begin
            settle(); check("mc_stallE", 32'(se_a), 32'd1); advance("mc_busy");
        end
        mc_done = 1;
        settle(); check("mc_done_stall", 32'(se_a), 32'd0); check("wd8_timeout", 32'(to_b), 32'd1);
        advance("mc_done");
        mc_done = 0; settle(); advance("mc_after");

        // Branch aborts a busy op.
        mc_start = 1; settle(); advance("mc_start2");
        mc_start = 0;
        for (int i = 0; i < 3; i++) begin
            settle(); advance("mc_busy2");
        end
        branch_signal = 1;
        settle(); check("br_abort", 32'(ab_a), 32'd1); check("br_stallF", 32'(sf_a), 32'd0);
        advance("branch");
        branch_signal = 0;
        settle(); check("br_abort_once", 32'(ab_a), 32'd0); check("br_nostall", 32'(se_a), 32'd0);
        advance("post_branch");

        // Watchdog on the 8-cycle instance, then asynchronous reset mid-op.
        rst_n = 0; #1;
        check("async_clr_to", 32'(to_b), 32'd0);
        settle(); advance("rst2");
        rst_n = 1;
        mc_start = 1; settle(); advance("mc_start3");
        mc_start = 0;
        for (int i = 0; i < 8; i++) begin
            settle(); check("wd_pending", 32'(to_b), 32'd0); advance("wd_busy");
        end
        settle(); check("wd_sticky", 32'(to_b), 32'd1); check("wd_other_busy", 32'(se_a), 32'd1);
        advance("wd_fired");
        rst_n = 0; #1;
        check("async_rst_a", 32'(got_a), 32'd0);
        check("async_rst_b", 32'(got_b), 32'd0);
        settle(); advance("rst3");
        rst_n = 1;

        // Random traffic over a small register range to force collisions.
        for (int i = 0; i < 1500; i++) begin
            rs1_addrD    = 5'($urandom_range(0, 7));
            rs2_addrD    = 5'($urandom_range(0, 7));
            uses_rs1D    = 1'($urandom_range(0, 1));
            uses_rs2D    = 1'($urandom_range(0, 1));
            rs1_addrE    = 5'($urandom_range(0, 7));
            rs2_addrE    = 5'($urandom_range(0, 7));
            write_regE   = 1'($urandom_range(0, 1));
            dstreg_addrE = 5'($urandom_range(0, 7));
            info_loadE   = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            write_regM   = 1'($urandom_range(0, 1));
            dstreg_addrM = 5'($urandom_range(0, 7));
            write_regW   = 1'($urandom_range(0, 1));
            dstreg_addrW = 5'($urandom_range(0, 7));
            branch_signal = ($urandom_range(0, 11) == 0);
            mc_start     = !m_busy[0] && ($urandom_range(0, 15) == 0);
            mc_done      = ($urandom_range(0, 9) == 0);
            rst_n        = ($urandom_range(0, 299) != 0);
            settle();
            advance("rnd");
        end
        rst_n = 1;

`ifdef HAZARD_PERF_EN
        check("perf_ld_a", pld_a, 32'(p_ld[0]));
        check("perf_mc_a", pmc_a, 32'(p_mc[0]));
        check("perf_fl_a", pfl_a, 32'(p_fl[0]));
        check("perf_mc_b", pmc_b, 32'(p_mc[1]));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
